// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back control bit positions, the layout of
// the return word pushed by the memory stage, and the return-sequencer states.
package pipe_pkg;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int FLAGS_MSB = 31;
  localparam int FLAGS_LSB = 28;
  localparam int PC_MSB    = 27;

  localparam int FLUSH_CYCLES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } ret_state_e;

endpackage

// File: rtl/return_sequencer.sv
// RET/RTI control-flow return: unpacks the popped {flags, pc} word, issues the
// one-cycle PC/flag load strobes and holds flush for FLUSH_CYCLES+1 cycles.
module return_sequencer
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rti,
  input  logic [31:0] i_word,
  output logic        o_pcLoad,
  output logic [31:0] o_newPc,
  output logic        o_flagsLoad,
  output logic [3:0]  o_flags,
  output logic        o_flush,
  output logic        o_busy,
  output logic [1:0]  o_state
);

  ret_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [3:0]  flags_q, flags_d;
  logic        rti_q, rti_d;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      new_pc_q <= 32'd0;
      flags_q  <= 4'd0;
      rti_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
      flags_q  <= flags_d;
      rti_q    <= rti_d;
    end
  end

  // A start request is only honoured from IDLE; returns seen while busy are squashed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    flags_d  = flags_q;
    rti_d    = rti_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_REDIRECT;
          new_pc_d = {4'b0000, i_word[PC_MSB:0]};
          flags_d  = i_word[FLAGS_MSB:FLAGS_LSB];
          rti_d    = i_rti;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_DRAIN;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_pcLoad    = (state_q == ST_REDIRECT);
    o_flagsLoad = (state_q == ST_REDIRECT) & rti_q;
    o_flush     = (state_q != ST_IDLE);
    o_busy      = (state_q != ST_IDLE);
    o_newPc     = new_pc_q;
    o_flags     = flags_q;
    o_state     = state_q;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, ALU/memory write-data select,
// and the RET/RTI return sequencer.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic [1:0]  i_wb,
  input  logic [15:0] i_aluData,
  input  logic [31:0] i_memData,
  input  logic [2:0]  i_rdst,
  input  logic        i_isRet,
  input  logic        i_isRti,
  output logic        o_regWrite,
  output logic [2:0]  o_rdst,
  output logic [15:0] o_wbData,
  output logic        o_pcLoad,
  output logic [31:0] o_newPc,
  output logic        o_flagsLoad,
  output logic [3:0]  o_flags,
  output logic        o_flush,
  output logic        o_busy,
  output logic [1:0]  o_state
);

  logic        valid_q;
  logic [1:0]  wb_q;
  logic [15:0] alu_q;
  logic [31:0] mem_q;
  logic [2:0]  rdst_q;
  logic        is_ret_q;
  logic        is_rti_q;
  logic        capture;
  logic        start;

  assign capture = ~i_stall;
  assign start   = capture & i_valid & (i_isRet | i_isRti);

  // Anything captured while a return sequence is running is a squashed younger op.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      wb_q     <= 2'b00;
      alu_q    <= 16'd0;
      mem_q    <= 32'd0;
      rdst_q   <= 3'd0;
      is_ret_q <= 1'b0;
      is_rti_q <= 1'b0;
    end else if (capture) begin
      valid_q  <= i_valid & ~o_busy;
      wb_q     <= i_wb;
      alu_q    <= i_aluData;
      mem_q    <= i_memData;
      rdst_q   <= i_rdst;
      is_ret_q <= i_isRet;
      is_rti_q <= i_isRti;
    end
  end

  always_comb begin
    o_regWrite = valid_q & wb_q[WB_REGWRITE] & ~is_ret_q & ~is_rti_q;
    o_wbData   = wb_q[WB_MEMTOREG] ? mem_q[15:0] : alu_q;
    o_rdst     = rdst_q;
  end

  return_sequencer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_return_sequencer (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_start     (start),
    .i_rti       (i_isRti),
    .i_word      (i_memData),
    .o_pcLoad    (o_pcLoad),
    .o_newPc     (o_newPc),
    .o_flagsLoad (o_flagsLoad),
    .o_flags     (o_flags),
    .o_flush     (o_flush),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: write-back path, stall hold, RET/RTI sequences
// and reset abort, with hand-computed expected values.
module tb_wb_stage;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        i_stall;
  logic [1:0]  i_wb;
  logic [15:0] i_aluData;
  logic [31:0] i_memData;
  logic [2:0]  i_rdst;
  logic        i_isRet;
  logic        i_isRti;
  logic        o_regWrite;
  logic [2:0]  o_rdst;
  logic [15:0] o_wbData;
  logic        o_pcLoad;
  logic [31:0] o_newPc;
  logic        o_flagsLoad;
  logic [3:0]  o_flags;
  logic        o_flush;
  logic        o_busy;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_errors = 0;

  wb_stage #(.FLUSH_CYCLES(3)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .i_stall     (i_stall),
    .i_wb        (i_wb),
    .i_aluData   (i_aluData),
    .i_memData   (i_memData),
    .i_rdst      (i_rdst),
    .i_isRet     (i_isRet),
    .i_isRti     (i_isRti),
    .o_regWrite  (o_regWrite),
    .o_rdst      (o_rdst),
    .o_wbData    (o_wbData),
    .o_pcLoad    (o_pcLoad),
    .o_newPc     (o_newPc),
    .o_flagsLoad (o_flagsLoad),
    .o_flags     (o_flags),
    .o_flush     (o_flush),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_valid   = 1'b0;
    i_wb      = 2'b00;
    i_aluData = 16'd0;
    i_memData = 32'd0;
    i_rdst    = 3'd0;
    i_isRet   = 1'b0;
    i_isRti   = 1'b0;
  endtask

  task automatic drive_alu(input logic [15:0] data, input logic [2:0] rd);
    drive_idle();
    i_valid   = 1'b1;
    i_wb      = 2'b10;
    i_aluData = data;
    i_rdst    = rd;
  endtask

  task automatic drive_ret(input logic [31:0] word, input logic rti);
    drive_idle();
    i_valid   = 1'b1;
    i_memData = word;
    i_isRet   = ~rti;
    i_isRti   = rti;
  endtask

  initial begin
    i_reset = 1'b1;
    i_stall = 1'b0;
    drive_idle();
    step();
    step();
    i_reset = 1'b0;
    check_eq("rst_regWrite", 32'(o_regWrite), 32'd0);
    check_eq("rst_wbData", 32'(o_wbData), 32'd0);
    check_eq("rst_flush", 32'(o_flush), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_pcLoad", 32'(o_pcLoad), 32'd0);
    check_eq("rst_newPc", o_newPc, 32'd0);
    check_eq("rst_flags", 32'(o_flags), 32'd0);

    // ALU write-back
    drive_alu(16'h1234, 3'd5);
    step();
    check_eq("alu_regWrite", 32'(o_regWrite), 32'd1);
    check_eq("alu_rdst", 32'(o_rdst), 32'd5);
    check_eq("alu_wbData", 32'(o_wbData), 32'h1234);
    check_eq("alu_flush", 32'(o_flush), 32'd0);

    // load write-back selects low half of memory data
    drive_idle();
    i_valid   = 1'b1;
    i_wb      = 2'b11;
    i_aluData = 16'h7777;
    i_memData = 32'hDEAD_BEEF;
    i_rdst    = 3'd2;
    step();
    check_eq("ld_regWrite", 32'(o_regWrite), 32'd1);
    check_eq("ld_wbData", 32'(o_wbData), 32'hBEEF);

    // RET: redirect then 3 drain cycles, younger ALU op squashed throughout
    drive_ret(32'hA000_0123, 1'b0);
    i_wb = 2'b10;
    step();
    check_eq("ret_pcLoad", 32'(o_pcLoad), 32'd1);
    check_eq("ret_newPc", o_newPc, 32'h0000_0123);
    check_eq("ret_flagsLoad", 32'(o_flagsLoad), 32'd0);
    check_eq("ret_flags", 32'(o_flags), 32'hA);
    check_eq("ret_flush", 32'(o_flush), 32'd1);
    check_eq("ret_busy", 32'(o_busy), 32'd1);
    check_eq("ret_regWrite", 32'(o_regWrite), 32'd0);
    drive_alu(16'h5555, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("ret_drain%0d_flush", i), 32'(o_flush), 32'd1);
      check_eq($sformatf("ret_drain%0d_busy", i), 32'(o_busy), 32'd1);
      check_eq($sformatf("ret_drain%0d_pcLoad", i), 32'(o_pcLoad), 32'd0);
      check_eq($sformatf("ret_drain%0d_regWrite", i), 32'(o_regWrite), 32'd0);
    end
    step();
    check_eq("ret_end_flush", 32'(o_flush), 32'd0);
    check_eq("ret_end_busy", 32'(o_busy), 32'd0);
    check_eq("ret_end_regWrite", 32'(o_regWrite), 32'd0);
    check_eq("ret_hold_newPc", o_newPc, 32'h0000_0123);
    drive_idle();
    step();

    // RTI: flags restored alongside the redirect
    drive_ret(32'h5000_0040, 1'b1);
    step();
    check_eq("rti_pcLoad", 32'(o_pcLoad), 32'd1);
    check_eq("rti_flagsLoad", 32'(o_flagsLoad), 32'd1);
    check_eq("rti_newPc", o_newPc, 32'h0000_0040);
    check_eq("rti_flags", 32'(o_flags), 32'h5);
    drive_idle();
    step();
    check_eq("rti_flagsLoad_off", 32'(o_flagsLoad), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check_eq("rti_end_busy", 32'(o_busy), 32'd0);

    // stall holds the captured op while inputs change
    drive_alu(16'h0BAD, 3'd6);
    step();
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      i_valid   = 1'b1;
      i_wb      = 2'b11;
      i_aluData = 16'(32'hF000 + i);
      i_memData = 32'h1111_2222 + 32'(i);
      i_rdst    = 3'd1;
      step();
      check_eq($sformatf("stall%0d_wbData", i), 32'(o_wbData), 32'h0BAD);
      check_eq($sformatf("stall%0d_rdst", i), 32'(o_rdst), 32'd6);
      check_eq($sformatf("stall%0d_regWrite", i), 32'(o_regWrite), 32'd1);
    end
    i_stall = 1'b0;
    drive_idle();
    step();

    // reset in the second drain cycle aborts the sequence
    drive_ret(32'h3000_0200, 1'b0);
    step();
    drive_idle();
    step();
    step();
    check_eq("abort_pre_flush", 32'(o_flush), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check_eq("abort_flush", 32'(o_flush), 32'd0);
    check_eq("abort_busy", 32'(o_busy), 32'd0);
    check_eq("abort_pcLoad", 32'(o_pcLoad), 32'd0);
    check_eq("abort_regWrite", 32'(o_regWrite), 32'd0);
    check_eq("abort_newPc", o_newPc, 32'd0);
    drive_alu(16'h4321, 3'd2);
    step();
    check_eq("post_regWrite", 32'(o_regWrite), 32'd1);
    check_eq("post_wbData", 32'(o_wbData), 32'h4321);
    check_eq("post_flush", 32'(o_flush), 32'd0);
    drive_idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage directly downstream of the memory stage. Holds the MEM/WB pipeline register, selects ALU or memory data for the register file, and runs the control-flow return sequence for RET/RTI. For RET/RTI it unpacks the popped `{flags[3:0], pc[27:0]}` word, redirects the PC, optionally restores flags, and flushes younger instructions for a fixed number of cycles.

## Interface
- `FLUSH_CYCLES`, default 3: number of cycles `o_flush` stays high after a redirect (legal range 1..15).
- `clk  in  1`: single clock. All state updates on the rising edge.
- `i_reset  in  1`: synchronous, active-high reset.
- `i_valid  in  1`: the memory stage presents a real instruction.
- `i_stall  in  1`: hold the stage register (no capture).
- `i_wb  in  2`: bit1 = regWrite, bit0 = memToReg. This is the memory stage's `o_wb`.
- `i_aluData  in  16`: ALU result passed through the memory stage.
- `i_memData  in  32`: memory read data.
- `i_rdst  in  3`: destination register index.
- `i_isRet`, `i_isRti  in  1 each`: the instruction is RET or RTI.
- `o_regWrite  out  1`: register-file write enable.
- `o_rdst  out  3`: register-file write address; also used for forwarding.
- `o_wbData  out  16`: register-file write data; also used for forwarding.
- `o_pcLoad  out  1`: one-cycle PC redirect strobe.
- `o_newPc  out  32`: redirect target.
- `o_flagsLoad  out  1`: one-cycle flag-restore strobe.
- `o_flags  out  4`: restored flags.
- `o_flush  out  1`: squash younger pipeline stages.
- `o_busy  out  1`: a return sequence is in progress.

## Operation
- **Stage register** holds valid, wb, aluData, memData, rdst, isRet, isRti.
  - Captured on each edge when `i_stall`=0.
  - Held when `i_stall`=1.
  - Captured valid is forced to 0 whenever the FSM is not IDLE; younger instructions are squashed.
- **Write-back path:**
  - `o_regWrite` = reg.valid & reg.wb[1] & ~reg.isRet & ~reg.isRti.
  - `o_wbData` = reg.wb[0] ? reg.memData[15:0] : reg.aluData.
  - `o_rdst` = reg.rdst.
- **FSM states:** IDLE, REDIRECT, DRAIN.
  - IDLE → REDIRECT on an edge that captures (`i_stall`=0) `i_valid` & (`i_isRet` | `i_isRti`). On the same edge, load newPc = {4'b0, i_memData[27:0]} and flags = i_memData[31:28], and latch the rti bit.
  - REDIRECT: `o_pcLoad`=1; `o_flagsLoad`=rti bit; `o_flush`=1. Load the counter with FLUSH_CYCLES−1. Always go to DRAIN next cycle.
  - DRAIN: `o_flush`=1. Decrement the counter; return to IDLE on the edge where the counter is 0.
- `o_busy` = (state ≠ IDLE).
- `o_newPc` and `o_flags` hold their last loaded values until the next return sequence.
- **Boundary cases:**
  - A RET/RTI arriving while busy is squashed like any other instruction.
  - `i_stall` during REDIRECT/DRAIN does not pause the FSM.
  - With FLUSH_CYCLES=1, DRAIN lasts one cycle.
- **Reset:**
  - Stage register valid=0, FSM=IDLE, counter=0, newPc=0, flags=0.
  - All outputs read 0 in the cycle after reset.
  - Reset mid-sequence aborts immediately: no further pcLoad or flush.

## Timing
- MEM→WB latency is 1 cycle: data captured at edge N drives `o_regWrite`/`o_wbData` during cycle N→N+1.
- Redirect: a RET captured at edge N gives `o_pcLoad` high for exactly cycle N→N+1.
- `o_flush` is high for FLUSH_CYCLES+1 cycles in total: REDIRECT plus FLUSH_CYCLES in DRAIN.
- `o_busy` has the same span as `o_flush`.
- Outputs are driven from registered state only, with no combinational path from inputs. The exception is `o_regWrite`/`o_wbData`, which are combinational from the stage register.

## Structure
- **Shared package** (`pipe_pkg`):
  - wb field bit positions (WB_REGWRITE=1, WB_MEMTOREG=0).
  - FSM state enum.
  - Pushed-word layout constants: FLAGS_MSB=31, FLAGS_LSB=28, PC_MSB=27. These match the memory stage's push format `(pc+1) | flags<<28`.
  - Default FLUSH_CYCLES.
- **Sub-module:** `return_sequencer`, containing the FSM, counter, newPc/flags registers and the strobe outputs. The top level keeps the stage register and write-back mux.

## Test plan
- ALU write-back: valid, wb=2'b10, aluData=0x1234, rdst=5 → next cycle regWrite=1, rdst=5, wbData=0x1234; no flush.
- Load write-back: wb=2'b11, memData=0xDEAD_BEEF → wbData=0xBEEF, regWrite=1.
- RET with memData=0xA000_0123, FLUSH_CYCLES=3:
  - pcLoad for 1 cycle with newPc=0x0000_0123, flagsLoad=0.
  - flush and busy high for 4 cycles.
  - regWrite=0.
  - An ALU instruction presented during those cycles is never written.
- RTI with memData=0x5000_0040 → pcLoad and flagsLoad together, newPc=0x40, flags=4'h5.
- Stall: capture an ALU op, then hold `i_stall`=1 for 3 cycles while the inputs change → outputs remain the captured op.
- Reset asserted in the 2nd DRAIN cycle → next cycle flush=busy=pcLoad=regWrite=0, newPc=0, and a following ALU op writes back normally.
